// File: rtl/wave_ctrl.sv
// wave_ctrl - game-flow controller downstream of the kill counter.
//
// Tracks the running 4-bit kill total against a per-wave base. It declares
// a wave cleared, runs a timed intermission between waves, and pulses
// respawns for the four monster slots. It also reports wave number,
// progress and win/lose status.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high
//   start         one-cycle pulse; begins a game from IDLE, WIN or LOSE
//   kills[3:0]    running kill total (non-decreasing mod 16, steps 0..4)
//   player_dead   level; player has died
//   spawn[3:0]    one-cycle respawn pulse, one bit per monster slot
//   wave[1:0]     current wave 1..MAX_WAVE, 0 in IDLE
//   progress[3:0] kills in the current wave, saturated at KILLS_PER_WAVE
//   intermission  high while between waves
//   win           high while the game is won
//   lose          high while the game is lost
//
// All outputs decode from registers; there are no combinational input paths.
module wave_ctrl #(
    parameter int          KILLS_PER_WAVE = 4,
    parameter int          MAX_WAVE       = 3,
    parameter logic [15:0] INTER_CYC      = 16'd100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] kills,
    input  logic       player_dead,
    output logic [3:0] spawn,
    output logic [1:0] wave,
    output logic [3:0] progress,
    output logic       intermission,
    output logic       win,
    output logic       lose
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SPAWN = 3'd1;
    localparam logic [2:0] S_FIGHT = 3'd2;
    localparam logic [2:0] S_INTER = 3'd3;
    localparam logic [2:0] S_WIN   = 3'd4;
    localparam logic [2:0] S_LOSE  = 3'd5;

    localparam logic [3:0] KPW  = 4'(KILLS_PER_WAVE);
    localparam logic [1:0] MAXW = 2'(MAX_WAVE);

    logic [2:0]  r_state;
    logic [1:0]  r_wave;
    logic [3:0]  r_base;
    logic [3:0]  r_progress;
    logic [15:0] r_timer;

    logic [3:0]  w_diff;
    logic [3:0]  w_diff_sat;
    logic        w_cleared;

    // Kill total wraps mod 16; subtracting in 4 bits gives the wrapped
    // distance. KILLS_PER_WAVE <= 12 keeps this free of aliasing even
    // with 4-kill jumps.
    always_comb begin
        w_diff     = kills - r_base;
        w_cleared  = (w_diff >= KPW);
        w_diff_sat = w_cleared ? KPW : w_diff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wave     <= 2'd0;
            r_base     <= 4'd0;
            r_progress <= 4'd0;
            r_timer    <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SPAWN;
                        r_wave  <= 2'd1;
                    end
                end
                S_SPAWN: begin
                    // Latching base here discards any kills made during
                    // the intermission.
                    r_base  <= kills;
                    r_state <= S_FIGHT;
                end
                S_FIGHT: begin
                    r_progress <= w_diff_sat;
                    if (player_dead) begin
                        r_state <= S_LOSE;
                    end else if (w_cleared) begin
                        if (r_wave == MAXW) begin
                            r_state <= S_WIN;
                        end else begin
                            r_state <= S_INTER;
                            r_timer <= INTER_CYC - 16'd1;
                        end
                    end
                end
                S_INTER: begin
                    // Death beats timer expiry.
                    if (player_dead) begin
                        r_state <= S_LOSE;
                    end else if (r_timer == 16'd0) begin
                        r_wave     <= r_wave + 2'd1;
                        r_progress <= 4'd0;
                        r_state    <= S_SPAWN;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                S_WIN, S_LOSE: begin
                    if (start) begin
                        r_state    <= S_SPAWN;
                        r_wave     <= 2'd1;
                        r_progress <= 4'd0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign spawn        = (r_state == S_SPAWN) ? 4'b1111 : 4'b0000;
    assign wave         = r_wave;
    assign progress     = r_progress;
    assign intermission = (r_state == S_INTER);
    assign win          = (r_state == S_WIN);
    assign lose         = (r_state == S_LOSE);

endmodule

// File: tb/tb_wave_ctrl.sv
// tb_wave_ctrl - self-checking bench for wave_ctrl (INTER_CYC = 5).
// Directed scenarios followed by a randomized run. Every cycle is compared
// against a behavioural reference model, with extra constant checks at
// the scenario milestones.
module tb_wave_ctrl;

    localparam int K_PER_WAVE = 4;
    localparam int N_WAVES    = 3;
    localparam int N_INTER    = 5;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] kills;
    logic       player_dead;
    logic [3:0] spawn;
    logic [1:0] wave;
    logic [3:0] progress;
    logic       intermission;
    logic       win;
    logic       lose;

    int checks = 0;
    int errors = 0;

    logic [3:0] kv;

    // Reference model: phase names, with intermission tracked as elapsed cycles.
    typedef enum int {P_IDLE, P_SPAWN, P_FIGHT, P_INTER, P_WIN, P_LOSE} phase_t;
    phase_t m_phase;
    int     m_wave;
    int     m_base;
    int     m_prog;
    int     m_elapsed;

    wave_ctrl #(
        .KILLS_PER_WAVE(K_PER_WAVE),
        .MAX_WAVE      (N_WAVES),
        .INTER_CYC     (16'd5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .kills       (kills),
        .player_dead (player_dead),
        .spawn       (spawn),
        .wave        (wave),
        .progress    (progress),
        .intermission(intermission),
        .win         (win),
        .lose        (lose)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit st, input int k, input bit dead);
        int d;
        if (r) begin
            m_phase = P_IDLE; m_wave = 0; m_base = 0; m_prog = 0; m_elapsed = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (st) begin m_phase = P_SPAWN; m_wave = 1; end
                P_SPAWN: begin m_base = k; m_phase = P_FIGHT; end
                P_FIGHT: begin
                    d = (k - m_base + 16) % 16;
                    m_prog = (d > K_PER_WAVE) ? K_PER_WAVE : d;
                    if (dead) m_phase = P_LOSE;
                    else if (d >= K_PER_WAVE) begin
                        if (m_wave == N_WAVES) m_phase = P_WIN;
                        else begin m_phase = P_INTER; m_elapsed = 0; end
                    end
                end
                P_INTER: begin
                    if (dead) m_phase = P_LOSE;
                    else if (m_elapsed == N_INTER - 1) begin
                        m_wave++; m_prog = 0; m_phase = P_SPAWN;
                    end else m_elapsed++;
                end
                default: if (st) begin m_phase = P_SPAWN; m_wave = 1; m_prog = 0; end
            endcase
        end
    endtask

    task automatic compare_model();
        check("m_spawn", 16'(spawn), (m_phase == P_SPAWN) ? 16'hF : 16'h0);
        check("m_wave", 16'(wave), 16'(m_wave));
        check("m_progress", 16'(progress), 16'(m_prog));
        check("m_inter", 16'(intermission), 16'(m_phase == P_INTER));
        check("m_win", 16'(win), 16'(m_phase == P_WIN));
        check("m_lose", 16'(lose), 16'(m_phase == P_LOSE));
    endtask

    // One clock: drive at negedge, advance model at posedge, sample 1 unit later.
    task automatic step(input bit st, input int inc, input bit dead, input bit r);
        @(negedge clk);
        kv          = kv + 4'(inc);
        start       = st;
        player_dead = dead;
        rst         = r;
        kills       = kv;
        @(posedge clk);
        model_update(r, st, int'(kv), dead);
        #1;
        compare_model();
    endtask

    function automatic logic [15:0] all_outs();
        return {3'b0, spawn, wave, progress, intermission, win, lose};
    endfunction

    initial begin
        int ic;
        kv = 4'd0; rst = 1'b1; start = 1'b0; player_dead = 1'b0; kills = 4'd0;
        m_phase = P_IDLE; m_wave = 0; m_base = 0; m_prog = 0; m_elapsed = 0;

        // Reset for two cycles
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("rst_outs", all_outs(), 16'h0);

        // Start -> one spawn pulse, wave 1, then FIGHT with progress 0
        step(1, 0, 0, 0);
        check("start_spawn", 16'(spawn), 16'hF);
        check("start_wave", 16'(wave), 16'd1);
        step(0, 0, 0, 0);
        check("fight_spawn_off", 16'(spawn), 16'h0);
        check("fight_prog0", 16'(progress), 16'd0);

        // Clear wave 1 one kill at a time, then count intermission cycles
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 0, 0);
            check("prog_step", 16'(progress), 16'(i));
        end
        ic = int'(intermission);
        for (int j = 0; j < 4; j++) begin
            step(0, 0, 0, 0);
            ic += int'(intermission);
        end
        step(0, 0, 0, 0);
        ic += int'(intermission);
        check("inter_dwell", 16'(ic), 16'd5);
        check("wave2_spawn", 16'(spawn), 16'hF);
        check("wave2_num", 16'(wave), 16'd2);

        // Mod-16 wrap: base 14, kills jumps to 2
        step(0, 4, 0, 1);
        step(0, 4, 0, 1);
        step(0, 2, 0, 1);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 4, 0, 0);
        check("wrap_inter", 16'(intermission), 16'd1);
        check("wrap_prog", 16'(progress), 16'd4);

        // +4 jump from base 0 clears in one cycle
        step(0, 4, 0, 1);
        step(0, 4, 0, 1);
        step(0, 4, 0, 1);
        step(0, 2, 0, 1);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 4, 0, 0);
        check("jump4_inter", 16'(intermission), 16'd1);

        // Full win over three waves
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int w = 1; w <= 3; w++) begin
            step(0, 4, 0, 0);
            if (w < 3) for (int j = 0; j < 6; j++) step(0, 0, 0, 0);
        end
        check("win_flag", 16'(win), 16'd1);
        check("win_wave", 16'(wave), 16'd3);
        step(0, 3, 0, 0);
        step(0, 4, 1, 0);
        check("win_sticky", 16'(win), 16'd1);
        check("win_no_lose", 16'(lose), 16'd0);
        step(1, 0, 0, 0);
        check("restart_spawn", 16'(spawn), 16'hF);
        check("restart_wave", 16'(wave), 16'd1);
        check("restart_win_off", 16'(win), 16'd0);

        // Death beats wave clear in FIGHT
        step(0, 0, 0, 0);
        step(0, 4, 1, 0);
        check("lose_fight", 16'(lose), 16'd1);
        check("lose_not_inter", 16'(intermission), 16'd0);

        // Death beats timer expiry in INTER
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 4, 0, 0);
        for (int j = 0; j < 4; j++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        check("lose_inter", 16'(lose), 16'd1);
        check("lose_no_spawn", 16'(spawn), 16'h0);

        // Reset mid-intermission
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 4, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        check("midrst_outs", all_outs(), 16'h0);

        // start during FIGHT is ignored
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("fight_start_ign", 16'(spawn), 16'h0);
        step(0, 0, 0, 0);
        check("fight_start_ign2", 16'(spawn), 16'h0);

        // Randomized run
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 15) == 0,
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : 0,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 149) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
